// File: rtl/la_checkpoint_monitor.sv
`default_nettype none
// ============================================================================
// Module      : la_checkpoint_monitor
// Description : Ordered checkpoint sequencer. Watches a status word for DEPTH
//               programmable signatures, each with a minimum hold time and a
//               per-step timeout. Optional per-entry compare mask: LA_MON_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module la_checkpoint_monitor #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int TO_W     = 24,
    parameter int MIN_HOLD = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
`ifdef LA_MON_MASK_EN
    input  logic [WIDTH-1:0] cfg_mask,
`endif
    input  logic [AW:0]      cfg_num,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] chk_i,
    output logic             busy_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [AW:0]      step_o,
    output logic             match_o,
    output logic [WIDTH-1:0] fail_val_o
);

    localparam logic [1:0]      c_ST_IDLE   = 2'd0;
    localparam logic [1:0]      c_ST_ARMED  = 2'd1;
    localparam logic [1:0]      c_ST_PASS   = 2'd2;
    localparam logic [1:0]      c_ST_FAIL   = 2'd3;
    localparam logic [AW:0]     c_DEPTH     = (AW+1)'(DEPTH);
    localparam logic [AW:0]     c_STEP_ONE  = (AW+1)'(1);
    localparam logic [3:0]      c_HOLD_LAST = 4'(MIN_HOLD - 1);
    localparam logic [TO_W-1:0] c_TO_ONE    = TO_W'(1);

    logic [WIDTH-1:0] r_exp [DEPTH];
    logic [WIDTH-1:0] r_chk_q;
    logic [WIDTH-1:0] r_fail_val, w_fail_val_nxt;
    logic [1:0]       r_state, w_state_nxt;
    logic [AW:0]      r_step, w_step_nxt;
    logic [AW:0]      r_num, w_num_nxt;
    logic [3:0]       r_hold, w_hold_nxt;
    logic [TO_W-1:0]  r_tmo, w_tmo_nxt;
    logic [TO_W-1:0]  r_limit, w_limit_nxt;
    logic             r_match, w_match;
    logic [AW-1:0]    w_idx;
    logic [WIDTH-1:0] w_exp;
    logic [WIDTH-1:0] w_cmp_mask;
    logic             w_eq;

    assign w_idx = r_step[AW-1:0];
    assign w_exp = r_exp[w_idx];

`ifdef LA_MON_MASK_EN
    logic [WIDTH-1:0] r_mask [DEPTH];
    assign w_cmp_mask = r_mask[w_idx];
`else
    assign w_cmp_mask = '1;
`endif

    assign w_eq = ((r_chk_q ^ w_exp) & w_cmp_mask) == '0;

    // Signature storage is deliberately not reset; software reloads it.
    always_ff @(posedge wb_clk_i) begin
        if (cfg_we && !busy_o) begin
            r_exp[cfg_addr] <= cfg_data;
`ifdef LA_MON_MASK_EN
            r_mask[cfg_addr] <= cfg_mask;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        w_num_nxt      = r_num;
        w_limit_nxt    = r_limit;
        w_hold_nxt     = r_hold;
        w_tmo_nxt      = r_tmo;
        w_fail_val_nxt = r_fail_val;
        w_match        = 1'b0;
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
            w_step_nxt  = '0;
            w_hold_nxt  = '0;
            w_tmo_nxt   = '0;
        end else if (start) begin
            w_num_nxt   = (cfg_num > c_DEPTH) ? c_DEPTH : cfg_num;
            w_limit_nxt = cfg_timeout;
            w_step_nxt  = '0;
            w_hold_nxt  = '0;
            w_tmo_nxt   = '0;
            w_state_nxt = (w_num_nxt == '0) ? c_ST_PASS : c_ST_ARMED;
        end else if (r_state == c_ST_ARMED) begin
            // A match at the same edge as a timeout takes priority.
            if (w_eq && (r_hold == c_HOLD_LAST)) begin
                w_match    = 1'b1;
                w_step_nxt = r_step + c_STEP_ONE;
                w_hold_nxt = '0;
                w_tmo_nxt  = '0;
                if (r_step == r_num - c_STEP_ONE) begin
                    w_state_nxt = c_ST_PASS;
                end
            end else begin
                w_hold_nxt = w_eq ? r_hold + 4'd1 : 4'd0;
                if ((r_limit != '0) && (r_tmo == r_limit - c_TO_ONE)) begin
                    w_state_nxt    = c_ST_FAIL;
                    w_fail_val_nxt = r_chk_q;
                end else if (r_tmo != '1) begin
                    w_tmo_nxt = r_tmo + c_TO_ONE;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= c_ST_IDLE;
            r_step     <= '0;
            r_num      <= '0;
            r_limit    <= '0;
            r_hold     <= '0;
            r_tmo      <= '0;
            r_match    <= 1'b0;
            r_chk_q    <= '0;
            r_fail_val <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_num      <= w_num_nxt;
            r_limit    <= w_limit_nxt;
            r_hold     <= w_hold_nxt;
            r_tmo      <= w_tmo_nxt;
            r_match    <= w_match;
            r_chk_q    <= chk_i;
            r_fail_val <= w_fail_val_nxt;
        end
    end

    assign busy_o     = (r_state == c_ST_ARMED);
    assign pass_o     = (r_state == c_ST_PASS);
    assign fail_o     = (r_state == c_ST_FAIL);
    assign step_o     = r_step;
    assign match_o    = r_match;
    assign fail_val_o = r_fail_val;

endmodule
`default_nettype wire
